// File: rtl/cacheline_adaptor.sv
// Memory-side responder: turns one 256-bit cacheline read/write from the arbiter
// into a four-beat 64-bit burst on the physical memory port.
module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    output logic         resp_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    output logic [63:0]  burst_o,
    input  logic [63:0]  burst_i,
    input  logic         resp_i
);

    typedef enum logic [2:0] {IDLE, READ, RDONE, WRITE, WDONE} state_t;

    state_t       state;
    state_t       next_state;
    logic [1:0]   cnt;
    logic [255:0] line_buf;
    logic [31:0]  addr_reg;
    logic         last_beat;

    assign last_beat = resp_i && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Address and line are captured once at acceptance so later arbiter changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            line_buf <= 256'd0;
            addr_reg <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_i) begin
                        addr_reg <= address_i & 32'hFFFF_FFE0;
                        cnt      <= 2'd0;
                    end else if (write_i) begin
                        addr_reg <= address_i & 32'hFFFF_FFE0;
                        line_buf <= line_i;
                        cnt      <= 2'd0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_buf[{cnt, 6'd0} +: 64] <= burst_i;
                        cnt <= cnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (read_i) begin
                    next_state = READ;
                end else if (write_i) begin
                    next_state = WRITE;
                end
            end
            READ: begin
                if (last_beat) begin
                    next_state = RDONE;
                end
            end
            WRITE: begin
                if (last_beat) begin
                    next_state = WDONE;
                end
            end
            RDONE:   next_state = IDLE;
            WDONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so resp_o is never combinational from resp_i.
    always_comb begin
        resp_o    = (state == RDONE) || (state == WDONE);
        read_o    = (state == READ);
        write_o   = (state == WRITE);
        address_o = addr_reg;
        line_o    = line_buf;
        burst_o   = line_buf[63:0];
        if (state == WRITE) begin
            burst_o = line_buf[{cnt, 6'd0} +: 64];
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: directed read/write bursts, gaps,
// arbitration priority, mid-burst reset and stray memory acknowledges.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  address_i = 32'd0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic [255:0] line_i = 256'd0;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i = 64'd0;
    logic         resp_i = 1'b0;

    typedef struct {
        bit           is_write;
        logic [255:0] line;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared = 0;
    int   mismatched = 0;

    localparam logic [255:0] RD_LINE_1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WR_LINE_1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] RD_LINE_2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                          64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5};
    localparam logic [255:0] WR_LINE_2 = {64'h8000_0000_0000_0004, 64'h8000_0000_0000_0003,
                                          64'h8000_0000_0000_0002, 64'h8000_0000_0000_0001};
    localparam logic [255:0] RD_LINE_3 = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                                          64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
    localparam logic [255:0] RD_LINE_4 = {64'h1357_9BDF_0000_0003, 64'h1357_9BDF_0000_0002,
                                          64'h1357_9BDF_0000_0001, 64'h1357_9BDF_0000_0000};

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [255:0] line, input logic rsp, input logic [63:0] beat);
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = line;
        resp_i    = rsp;
        burst_i   = beat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a read in the current IDLE cycle, feeds four contiguous beats, and
    // finishes sampled in the IDLE cycle after RDONE. write_i is left untouched.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] data, input bit stray_done);
        exp_t e;
        e.is_write = 1'b0;
        e.line     = data;
        sb.push_back(e);
        address_i = addr;
        read_i    = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            resp_i  = 1'b1;
            burst_i = data[64*b +: 64];
            @(negedge clk);
            checkOutput("rd_read_o", read_o, 1);
            checkOutput("rd_address_o", address_o, addr & 32'hFFFF_FFE0);
            checkOutput("rd_resp_early", resp_o, 0);
            tick();
        end
        resp_i  = stray_done;
        burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        read_i  = 1'b0;
        @(negedge clk);
        checkOutput("rd_resp_o", resp_o, 1);
        checkOutput("rd_read_o_done", read_o, 0);
        checkOutput("rd_address_done", address_o, addr & 32'hFFFF_FFE0);
        tick();
        resp_i = 1'b0;
        @(negedge clk);
        checkOutput("rd_resp_after", resp_o, 0);
        checkOutput("rd_read_o_idle", read_o, 0);
    endtask

    // Issues a write; mask bit c raises resp_i in cycle c. With corrupt set the
    // arbiter inputs are scrambled in cycle 3 to prove they were latched.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] data,
                            input logic [16:0] mask, input bit corrupt);
        exp_t e;
        int   seen;
        int   c;
        e.is_write = 1'b1;
        e.line     = data;
        sb.push_back(e);
        address_i = addr;
        line_i    = data;
        write_i   = 1'b1;
        tick();
        seen = 0;
        c    = 1;
        while (seen < 4 && c <= 16) begin
            resp_i  = mask[c];
            burst_i = 64'hFFFF_0000_FFFF_0000;
            if (corrupt && c == 3) begin
                address_i = 32'hFFFF_FFFF;
                line_i    = ~data;
            end
            @(negedge clk);
            checkOutput("wr_write_o", write_o, 1);
            checkOutput("wr_burst_o", burst_o, data[64*seen +: 64]);
            checkOutput("wr_address_o", address_o, addr & 32'hFFFF_FFE0);
            checkOutput("wr_resp_early", resp_o, 0);
            if (mask[c]) seen++;
            tick();
            c++;
        end
        resp_i  = 1'b0;
        write_i = 1'b0;
        @(negedge clk);
        checkOutput("wr_resp_o", resp_o, 1);
        checkOutput("wr_write_o_done", write_o, 0);
        checkOutput("wr_done_cycle", c, mask[16] ? 17 : c);
        tick();
        @(negedge clk);
        checkOutput("wr_resp_after", resp_o, 0);
    endtask

    // Monitor: every resp_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (resp_o === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL sb_unexpected_resp: got resp_o=1 expected no response");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_write) begin
                    checkOutput("sb_wdone_strobes", {read_o, write_o}, 0);
                end else begin
                    checkOutput("sb_line_o", line_o, mon_e.line);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0, 1'b0, 64'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_resp_o", resp_o, 0);
        checkOutput("rst_read_o", read_o, 0);
        checkOutput("rst_write_o", write_o, 0);
        checkOutput("rst_address_o", address_o, 0);
        checkOutput("rst_burst_o", burst_o, 0);
        checkOutput("rst_line_o", line_o, 0);

        $display("[TB] read with contiguous beats");
        do_read(32'h0000_1234, RD_LINE_1, 1'b0);
        checkOutput("rd1_aligned", address_o, 32'h0000_1220);

        $display("[TB] write with gaps and inputs changed mid-burst");
        do_write(32'h0000_ABCD, WR_LINE_1, 17'h00264, 1'b1);

        $display("[TB] simultaneous read and write");
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, WR_LINE_2, 1'b0, 64'd0);
        do_read(32'h0000_0100, RD_LINE_2, 1'b0);
        checkOutput("prio_write_o_idle", write_o, 0);
        do_write(32'h0000_0100, WR_LINE_2, 17'h0001E, 1'b0);

        $display("[TB] reset after two read beats");
        applyStimulus(1'b1, 1'b0, 32'h0000_2040, 256'd0, 1'b0, 64'd0);
        tick();
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = 64'h7777_0000_0000_0000 | 64'(b);
            @(negedge clk);
            checkOutput("abort_read_o", read_o, 1);
            tick();
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_resp_o", resp_o, 0);
        checkOutput("abort_read_o_off", read_o, 0);
        checkOutput("abort_write_o", write_o, 0);
        checkOutput("abort_address_o", address_o, 0);
        checkOutput("abort_burst_o", burst_o, 0);
        checkOutput("abort_line_o", line_o, 0);
        tick();
        do_read(32'h0000_3000, RD_LINE_3, 1'b0);

        $display("[TB] stray acknowledges in IDLE and RDONE");
        resp_i  = 1'b1;
        burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
        @(negedge clk);
        checkOutput("stray_idle_read_o", read_o, 0);
        tick();
        resp_i = 1'b0;
        @(negedge clk);
        checkOutput("stray_idle_line_o", line_o, RD_LINE_3);
        checkOutput("stray_idle_resp_o", resp_o, 0);
        do_read(32'h0000_4444, RD_LINE_4, 1'b1);
        do_read(32'h0000_5000, RD_LINE_1, 1'b0);

        repeat (3) tick();
        checkOutput("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
